// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - two-stage pipelined RISC-V immediate packer with error flagging and transfer counter
module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      base_instr,
    input  logic [31:0]      imm,
    input  logic [2:0]       imm_selection,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] enc_count
);

    localparam logic [2:0] I_TYPE = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] U_TYPE = 3'd3;
    localparam logic [2:0] J_TYPE = 3'd4;

    logic        s1_valid;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic [2:0]  s1_sel;

    logic        s2_adv;
    logic        s1_adv;
    logic        in_fire;
    logic        xfer;
    logic [31:0] enc_instr;
    logic        enc_err;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s2_adv || !s1_valid;
    assign in_ready = resetn && s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Range checks look at the bits the format discards; packing happens regardless of error.
    always_comb begin
        enc_instr = s1_base;
        enc_err   = 1'b1;
        case (s1_sel)
            I_TYPE: begin
                enc_instr = {s1_imm[11:0], s1_base[19:0]};
                enc_err   = !((s1_imm[31:11] == '0) || (s1_imm[31:11] == '1));
            end
            S_TYPE: begin
                enc_instr = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
                enc_err   = !((s1_imm[31:11] == '0) || (s1_imm[31:11] == '1));
            end
            B_TYPE: begin
                enc_instr = {s1_imm[12], s1_imm[10:5], s1_base[24:12], s1_imm[4:1], s1_imm[11],
                             s1_base[6:0]};
                enc_err   = !((s1_imm[31:12] == '0) || (s1_imm[31:12] == '1)) || s1_imm[0];
            end
            U_TYPE: begin
                enc_instr = {s1_imm[31:12], s1_base[11:0]};
                enc_err   = (s1_imm[11:0] != '0);
            end
            J_TYPE: begin
                enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_base[11:0]};
                enc_err   = !((s1_imm[31:20] == '0) || (s1_imm[31:20] == '1)) || s1_imm[0];
            end
            default: begin
                enc_instr = s1_base;
                enc_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_base  <= '0;
            s1_imm   <= '0;
            s1_sel   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_base <= base_instr;
                s1_imm  <= imm;
                s1_sel  <= imm_selection;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= enc_instr;
                out_err   <= enc_err;
            end
        end
    end

    // A new error in the same cycle as clr_err must not be lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_sticky <= 1'b0;
            enc_count  <= '0;
        end else begin
            if (xfer && out_err) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
            if (xfer) begin
                enc_count <= enc_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - scoreboard bench for imm_pack with directed vectors
module tb_imm_pack;

    localparam int CNT_W = 4;
    localparam logic [2:0] I_T = 3'd0;
    localparam logic [2:0] S_T = 3'd1;
    localparam logic [2:0] B_T = 3'd2;
    localparam logic [2:0] U_T = 3'd3;
    localparam logic [2:0] J_T = 3'd4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      base_instr;
    logic [31:0]      imm;
    logic [2:0]       imm_selection;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic             clr_err;
    logic             err_sticky;
    logic [CNT_W-1:0] enc_count;

    imm_pack #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .base_instr    (base_instr),
        .imm           (imm),
        .imm_selection (imm_selection),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_err       (out_err),
        .clr_err       (clr_err),
        .err_sticky    (err_sticky),
        .enc_count     (enc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] im;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   model_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=0x%08h required=none", out_instr);
            end else begin
                mon_e = sb.pop_front();
                check("out_instr", out_instr, mon_e.instr);
                check("out_err", {31'b0, out_err}, {31'b0, mon_e.err});
            end
            model_count = (model_count + 1) % (1 << CNT_W);
        end
    end

    task automatic send(input vec_t v);
        int n = 0;
        in_valid      = 1'b1;
        imm_selection = v.sel;
        base_instr    = v.base;
        imm           = v.im;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end else begin
            sb.push_back({v.ei, v.ee});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
    endtask

    vec_t vecs[14];
    vec_t bp[3];

    initial begin
        vecs[0]  = '{I_T, 32'h00000013, 32'hFFFFF800, 32'h80000013, 1'b0};
        vecs[1]  = '{I_T, 32'h00000013, 32'h000007FF, 32'h7FF00013, 1'b0};
        vecs[2]  = '{I_T, 32'h00000013, 32'h00000800, 32'h80000013, 1'b1};
        vecs[3]  = '{S_T, 32'h00002023, 32'h000007FF, 32'h7E002FA3, 1'b0};
        vecs[4]  = '{S_T, 32'h00002023, 32'h00000800, 32'h80002023, 1'b1};
        vecs[5]  = '{B_T, 32'h00000063, 32'h00000FFE, 32'h7E000FE3, 1'b0};
        vecs[6]  = '{B_T, 32'h00000063, 32'h00000FFF, 32'h7E000FE3, 1'b1};
        vecs[7]  = '{U_T, 32'h00000037, 32'h12345001, 32'h12345037, 1'b1};
        vecs[8]  = '{U_T, 32'h00000037, 32'h12345000, 32'h12345037, 1'b0};
        vecs[9]  = '{J_T, 32'h0000006F, 32'h00000800, 32'h0010006F, 1'b0};
        vecs[10] = '{J_T, 32'h0000006F, 32'h00000801, 32'h0010006F, 1'b1};
        vecs[11] = '{3'd7, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[12] = '{I_T, 32'hFFFFFFFF, 32'h00000000, 32'h000FFFFF, 1'b0};
        vecs[13] = '{U_T, 32'hFFFFFFFF, 32'h00000000, 32'h00000FFF, 1'b0};
        bp[0]    = '{I_T, 32'h00000013, 32'h00000001, 32'h00100013, 1'b0};
        bp[1]    = '{I_T, 32'h00000013, 32'h00000002, 32'h00200013, 1'b0};
        bp[2]    = '{I_T, 32'h00000013, 32'h00000003, 32'h00300013, 1'b0};
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   idx;
        vec_t v;
        time  t0;
        resetn = 1'b0; in_valid = 1'b0; base_instr = '0; imm = '0;
        imm_selection = '0; out_ready = 1'b1; clr_err = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_enc_count", {28'b0, enc_count}, 32'd0);
        check("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Latency: output appears on the second edge after the accept cycle
        send(vecs[0]);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_not_yet", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        drain();

        for (int i = 1; i < 14; i++) send(vecs[i]);
        drain();
        check("enc_count_vectors", {28'b0, enc_count}, 32'(model_count));
        check("enc_count_14", {28'b0, enc_count}, 32'd14);
        check("sticky_after_err", {31'b0, err_sticky}, 32'd1);

        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("sticky_cleared", {31'b0, err_sticky}, 32'd0);

        // Erroring transfer on the same edge as clr_err
        out_ready = 1'b0;
        send(vecs[2]);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("err_item_waiting", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("sticky_set_wins", {31'b0, err_sticky}, 32'd1);

        // Backpressure: in_valid held with out_ready low
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        imm_selection = bp[0].sel; base_instr = bp[0].base; imm = bp[0].im;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("bp_stable_instr", out_instr, bp[0].ei);
                check("bp_stable_valid", {31'b0, out_valid}, 32'd1);
            end
            if (in_ready) begin
                sb.push_back({bp[idx].ei, bp[idx].ee});
                idx++;
            end
            @(posedge clk); #1;
            v = bp[(idx > 2) ? 2 : idx];
            imm_selection = v.sel; base_instr = v.base; imm = v.im;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        drain();
        check("bp_enc_count", {28'b0, enc_count}, 32'(model_count));

        // Reset mid-cycle with both stages full
        out_ready = 1'b0;
        send(bp[0]);
        send(bp[1]);
        in_valid = 1'b0;
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_instr", out_instr, 32'd0);
        check("midrst_enc_count", {28'b0, enc_count}, 32'd0);
        check("midrst_sticky", {31'b0, err_sticky}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        sb.delete();
        model_count = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_stale_output", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // 17 back-to-back transfers wrap a 4-bit counter to 1
        t0 = $time;
        for (int i = 0; i < 17; i++) begin
            v = '{I_T, 32'h00000013, 32'(i), (32'(i) << 20) | 32'h13, 1'b0};
            send(v);
        end
        check("throughput_cycles", 32'(($time - t0) / 10), 32'd17);
        drain();
        check("enc_count_wrap", {28'b0, enc_count}, 32'd1);
        check("enc_count_model", {28'b0, enc_count}, 32'(model_count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
